// File: rtl/decode_stage_pkg.sv
// Shared RV32I opcode constants, ALU op encodings and the decoded control bundle.
package decode_stage_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    src1_pc;
        logic    src2_imm;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    is_branch;
        logic    is_jump;
        logic    illegal;
    } ctrl_t;

    // alt is instr[30]; it selects SUB only for register-register ops, SRA for both.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt,
                                                input logic is_op);
        case (f3)
            3'b000:  return (alt && is_op) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_instr_decoder.sv
// Combinational RV32I decoder: instruction word to control bundle, immediate and source usage.
module instr_decoder
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output ctrl_t           ctrl_o,
    output logic [XLEN-1:0] imm_o,
    output logic            uses_rs1_o,
    output logic            uses_rs2_o
);

    logic [6:0]      opcode;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instr_i[6:0];
    assign imm_i  = XLEN'($signed(instr_i[31:20]));
    assign imm_s  = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
    assign imm_b  = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({instr_i[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));

    always_comb begin
        ctrl_o        = '0;
        ctrl_o.alu_op = ALU_ADD;
        imm_o         = '0;
        uses_rs1_o    = 1'b1;
        uses_rs2_o    = 1'b0;
        case (opcode)
            OPC_LUI: begin
                ctrl_o.alu_op    = ALU_PASS_B;
                ctrl_o.src2_imm  = 1'b1;
                ctrl_o.reg_write = 1'b1;
                imm_o            = imm_u;
                uses_rs1_o       = 1'b0;
            end
            OPC_AUIPC: begin
                ctrl_o.src1_pc   = 1'b1;
                ctrl_o.src2_imm  = 1'b1;
                ctrl_o.reg_write = 1'b1;
                imm_o            = imm_u;
                uses_rs1_o       = 1'b0;
            end
            OPC_JAL: begin
                ctrl_o.src1_pc   = 1'b1;
                ctrl_o.src2_imm  = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.is_jump   = 1'b1;
                imm_o            = imm_j;
                uses_rs1_o       = 1'b0;
            end
            OPC_JALR: begin
                ctrl_o.src2_imm  = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.is_jump   = 1'b1;
                imm_o            = imm_i;
            end
            OPC_BRANCH: begin
                ctrl_o.alu_op    = ALU_SUB;
                ctrl_o.is_branch = 1'b1;
                imm_o            = imm_b;
                uses_rs2_o       = 1'b1;
            end
            OPC_LOAD: begin
                ctrl_o.src2_imm  = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.mem_read  = 1'b1;
                imm_o            = imm_i;
            end
            OPC_STORE: begin
                ctrl_o.src2_imm  = 1'b1;
                ctrl_o.mem_write = 1'b1;
                imm_o            = imm_s;
                uses_rs2_o       = 1'b1;
            end
            OPC_OPIMM: begin
                ctrl_o.alu_op    = alu_from_funct3(instr_i[14:12], instr_i[30], 1'b0);
                ctrl_o.src2_imm  = 1'b1;
                ctrl_o.reg_write = 1'b1;
                imm_o            = imm_i;
            end
            OPC_OP: begin
                ctrl_o.alu_op    = alu_from_funct3(instr_i[14:12], instr_i[30], 1'b1);
                ctrl_o.reg_write = 1'b1;
                uses_rs2_o       = 1'b1;
            end
            default: ctrl_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: drives register-file read addresses and registers decoded controls
// on the same edge the register file returns data; owns load-use, backpressure and flush.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_ready,
    input  logic            flush,
    input  logic            ex_ready,
    output logic [RAW-1:0]  rf_rs1_addr,
    output logic [RAW-1:0]  rf_rs2_addr,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_imm,
    output logic [RAW-1:0]  ex_rs1,
    output logic [RAW-1:0]  ex_rs2,
    output logic [RAW-1:0]  ex_rd,
    output logic [3:0]      ex_alu_op,
    output logic            ex_src1_pc,
    output logic            ex_src2_imm,
    output logic [2:0]      ex_funct3,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_is_branch,
    output logic            ex_is_jump,
    output logic            ex_illegal
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [RAW-1:0]  rs1;
        logic [RAW-1:0]  rs2;
        logic [RAW-1:0]  rd;
        logic [2:0]      funct3;
        ctrl_t           ctrl;
    } ex_t;

    ex_t             ex_q, ex_d;
    ctrl_t           dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    logic            uses_rs1, uses_rs2;
    logic [RAW-1:0]  in_rs1, in_rs2, in_rd;
    logic            hold, load_use;

    instr_decoder #(.XLEN(XLEN)) u_dec (
        .instr_i    (if_instr[31:0]),
        .ctrl_o     (dec_ctrl),
        .imm_o      (dec_imm),
        .uses_rs1_o (uses_rs1),
        .uses_rs2_o (uses_rs2)
    );

    assign in_rs1 = if_instr[15 +: RAW];
    assign in_rs2 = if_instr[20 +: RAW];
    assign in_rd  = if_instr[7 +: RAW];

    assign hold     = ex_q.valid & ~ex_ready;
    assign load_use = ex_q.valid & ex_q.ctrl.mem_read & (ex_q.rd != '0) & if_valid &
                      ((uses_rs1 & (in_rs1 == ex_q.rd)) | (uses_rs2 & (in_rs2 == ex_q.rd)));
    assign if_ready = ~hold & ~load_use & ~flush;

    // While held, re-read the held sources so same-cycle writebacks reach execute.
    assign rf_rs1_addr = hold ? ex_q.rs1 : in_rs1;
    assign rf_rs2_addr = hold ? ex_q.rs2 : in_rs2;

    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d.valid = 1'b0;
        end else if (hold) begin
            ex_d = ex_q;
        end else if (load_use) begin
            ex_d.valid = 1'b0;
        end else if (if_valid) begin
            ex_d.valid  = 1'b1;
            ex_d.pc     = if_pc;
            ex_d.imm    = dec_imm;
            ex_d.rs1    = in_rs1;
            ex_d.rs2    = in_rs2;
            ex_d.rd     = dec_ctrl.reg_write ? in_rd : '0;
            ex_d.funct3 = if_instr[14:12];
            ex_d.ctrl   = dec_ctrl;
        end else begin
            ex_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    assign ex_valid     = ex_q.valid;
    assign ex_pc        = ex_q.pc;
    assign ex_imm       = ex_q.imm;
    assign ex_rs1       = ex_q.rs1;
    assign ex_rs2       = ex_q.rs2;
    assign ex_rd        = ex_q.rd;
    assign ex_alu_op    = ex_q.ctrl.alu_op;
    assign ex_src1_pc   = ex_q.ctrl.src1_pc;
    assign ex_src2_imm  = ex_q.ctrl.src2_imm;
    assign ex_funct3    = ex_q.funct3;
    assign ex_reg_write = ex_q.ctrl.reg_write;
    assign ex_mem_read  = ex_q.ctrl.mem_read;
    assign ex_mem_write = ex_q.ctrl.mem_write;
    assign ex_is_branch = ex_q.ctrl.is_branch;
    assign ex_is_jump   = ex_q.ctrl.is_jump;
    assign ex_illegal   = ex_q.ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage with hand-computed expectations.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n, if_valid, flush, ex_ready;
    logic [31:0] if_instr, if_pc;
    logic        if_ready;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_alu_op;
    logic        ex_src1_pc, ex_src2_imm;
    logic [2:0]  ex_funct3;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch, ex_is_jump, ex_illegal;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .RAW(5)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_ready(if_ready), .flush(flush), .ex_ready(ex_ready),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
        .ex_src1_pc(ex_src1_pc), .ex_src2_imm(ex_src2_imm), .ex_funct3(ex_funct3),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_illegal(ex_illegal)
    );

    logic [113:0] all_ex;
    assign all_ex = {ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_alu_op, ex_src1_pc,
                     ex_src2_imm, ex_funct3, ex_reg_write, ex_mem_read, ex_mem_write,
                     ex_is_branch, ex_is_jump, ex_illegal};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_valid = 1'b1; if_instr = 32'h00500093; if_pc = 32'h0;
        flush = 1'b0; ex_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (all_ex !== '0) begin n_err++; $display("FAIL reset_ex_all cyc%0d: got %0h want 0", i, all_ex); end
        end
        rst_n = 1'b1; if_valid = 1'b0;
        #1;
        n_cmp++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL reset_if_ready: got %0b want 1", if_ready); end
    endtask

    task automatic test_addi();
        if_valid = 1'b1; if_instr = 32'h00500093; if_pc = 32'h100;
        #1;
        n_cmp++; if (rf_rs1_addr !== 5'd0) begin n_err++; $display("FAIL addi_rf_rs1: got %0d want 0", rf_rs1_addr); end
        n_cmp++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL addi_if_ready: got %0b want 1", if_ready); end
        tick();
        if_valid = 1'b0;
        n_cmp++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid: got %0b want 1", ex_valid); end
        n_cmp++; if (ex_pc !== 32'h100) begin n_err++; $display("FAIL addi_pc: got %0h want 100", ex_pc); end
        n_cmp++; if (ex_rd !== 5'd1) begin n_err++; $display("FAIL addi_rd: got %0d want 1", ex_rd); end
        n_cmp++; if (ex_imm !== 32'd5) begin n_err++; $display("FAIL addi_imm: got %0h want 5", ex_imm); end
        n_cmp++; if (ex_alu_op !== 4'd0) begin n_err++; $display("FAIL addi_alu: got %0d want 0", ex_alu_op); end
        n_cmp++; if ({ex_src2_imm, ex_reg_write, ex_src1_pc, ex_mem_read} !== 4'b1100) begin
            n_err++; $display("FAIL addi_ctrl: got %b want 1100", {ex_src2_imm, ex_reg_write, ex_src1_pc, ex_mem_read}); end
    endtask

    task automatic test_load_use();
        if_valid = 1'b1; if_instr = 32'h0000A103; if_pc = 32'h104;
        tick();
        n_cmp++; if ({ex_valid, ex_mem_read, ex_rd, ex_rs1} !== {1'b1, 1'b1, 5'd2, 5'd1}) begin
            n_err++; $display("FAIL lw_accept: got %b want 11_00010_00001", {ex_valid, ex_mem_read, ex_rd, ex_rs1}); end
        if_instr = 32'h002101B3; if_pc = 32'h108;
        #1;
        n_cmp++; if (if_ready !== 1'b0) begin n_err++; $display("FAIL lu_if_ready_stall: got %0b want 0", if_ready); end
        tick();
        n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble: got %0b want 0", ex_valid); end
        n_cmp++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL lu_if_ready_resume: got %0b want 1", if_ready); end
        tick();
        n_cmp++; if ({ex_valid, ex_rs1, ex_rs2, ex_rd} !== {1'b1, 5'd2, 5'd2, 5'd3}) begin
            n_err++; $display("FAIL lu_add_fields: got %b want 1_00010_00010_00011", {ex_valid, ex_rs1, ex_rs2, ex_rd}); end
        n_cmp++; if ({ex_pc, ex_alu_op, ex_src2_imm} !== {32'h108, 4'd0, 1'b0}) begin
            n_err++; $display("FAIL lu_add_ctrl: got %h want 108_0_0", {ex_pc, ex_alu_op, ex_src2_imm}); end
    endtask

    task automatic test_hold();
        ex_ready = 1'b0; if_valid = 1'b1; if_instr = 32'h00700213; if_pc = 32'h10C;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if ({if_ready, rf_rs1_addr, rf_rs2_addr} !== {1'b0, 5'd2, 5'd2}) begin
                n_err++; $display("FAIL hold_comb cyc%0d: got %b want 0_00010_00010", i, {if_ready, rf_rs1_addr, rf_rs2_addr}); end
            tick();
            n_cmp++; if ({ex_valid, ex_pc, ex_rd} !== {1'b1, 32'h108, 5'd3}) begin
                n_err++; $display("FAIL hold_stable cyc%0d: got %h want 1_108_3", i, {ex_valid, ex_pc, ex_rd}); end
        end
        ex_ready = 1'b1;
        #1;
        n_cmp++; if ({if_ready, rf_rs1_addr, rf_rs2_addr} !== {1'b1, 5'd0, 5'd7}) begin
            n_err++; $display("FAIL hold_release_comb: got %b want 1_00000_00111", {if_ready, rf_rs1_addr, rf_rs2_addr}); end
        tick();
        n_cmp++; if ({ex_valid, ex_pc, ex_rd, ex_imm} !== {1'b1, 32'h10C, 5'd4, 32'd7}) begin
            n_err++; $display("FAIL hold_next: got %h want 1_10c_4_7", {ex_valid, ex_pc, ex_rd, ex_imm}); end
    endtask

    task automatic test_flush();
        ex_ready = 1'b0; flush = 1'b1; if_valid = 1'b1; if_instr = 32'h00900293; if_pc = 32'h110;
        #1;
        n_cmp++; if (if_ready !== 1'b0) begin n_err++; $display("FAIL flush_if_ready: got %0b want 0", if_ready); end
        tick();
        n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %0b want 0", ex_valid); end
        flush = 1'b0; ex_ready = 1'b1;
        #1;
        n_cmp++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL flush_pending_ready: got %0b want 1", if_ready); end
        tick();
        n_cmp++; if ({ex_valid, ex_pc, ex_rd, ex_imm} !== {1'b1, 32'h110, 5'd5, 32'd9}) begin
            n_err++; $display("FAIL flush_pending_accept: got %h want 1_110_5_9", {ex_valid, ex_pc, ex_rd, ex_imm}); end
    endtask

    task automatic test_branch_illegal();
        if_valid = 1'b1; if_instr = 32'hFE000EE3; if_pc = 32'h200;
        tick();
        n_cmp++; if (ex_imm !== 32'hFFFFFFFC) begin n_err++; $display("FAIL beq_imm: got %h want fffffffc", ex_imm); end
        n_cmp++; if ({ex_valid, ex_is_branch, ex_alu_op, ex_rd, ex_reg_write, ex_src2_imm} !== {1'b1, 1'b1, 4'd1, 5'd0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL beq_ctrl: got %b want 11_0001_00000_00", {ex_valid, ex_is_branch, ex_alu_op, ex_rd, ex_reg_write, ex_src2_imm}); end
        if_instr = 32'hFFFFFFFF; if_pc = 32'h204;
        tick();
        n_cmp++; if ({ex_valid, ex_illegal} !== 2'b11) begin n_err++; $display("FAIL ill_flag: got %b want 11", {ex_valid, ex_illegal}); end
        n_cmp++; if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch, ex_is_jump, ex_rd} !== 10'd0) begin
            n_err++; $display("FAIL ill_ctrl: got %b want 0", {ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch, ex_is_jump, ex_rd}); end
    endtask

    task automatic test_back_to_back();
        if_valid = 1'b1; if_instr = 32'h12345337; if_pc = 32'h300;
        tick();
        n_cmp++; if ({ex_valid, ex_imm, ex_alu_op, ex_rd} !== {1'b1, 32'h12345000, 4'd10, 5'd6}) begin
            n_err++; $display("FAIL lui: got %h want 1_12345000_a_6", {ex_valid, ex_imm, ex_alu_op, ex_rd}); end
        if_instr = 32'h402083B3; if_pc = 32'h304;
        tick();
        n_cmp++; if ({ex_valid, ex_pc, ex_alu_op, ex_rd} !== {1'b1, 32'h304, 4'd1, 5'd7}) begin
            n_err++; $display("FAIL sub: got %h want 1_304_1_7", {ex_valid, ex_pc, ex_alu_op, ex_rd}); end
        if_instr = 32'h0000A003; if_pc = 32'h308;
        tick();
        if_instr = 32'h000001B3; if_pc = 32'h30C;
        #1;
        n_cmp++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL lw_x0_no_interlock: got %0b want 1", if_ready); end
        tick();
        n_cmp++; if ({ex_valid, ex_pc, ex_rd} !== {1'b1, 32'h30C, 5'd3}) begin
            n_err++; $display("FAIL lw_x0_next: got %h want 1_30c_3", {ex_valid, ex_pc, ex_rd}); end
        if_valid = 1'b0;
        tick();
        n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL idle_drain: got %0b want 0", ex_valid); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use();
        test_hold();
        test_flush();
        test_branch_illegal();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I instruction-decode pipeline stage.
- Sits between fetch and execute, and drives the register-file read addresses.
- The register file returns read data one cycle after the address, so the decoded controls are registered on that same edge. Execute then sees the register-file data and `ex_*` aligned.
- Also owns the load-use interlock, downstream backpressure and the flush bubble.

Parameters:
- `XLEN`, 32, datapath and instruction width.
- `RAW`, 5, register address width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `if_valid`  in  1  fetch presents an instruction.
- `if_instr`  in  `XLEN`  instruction word.
- `if_pc`  in  `XLEN`  PC of `if_instr`.
- `if_ready`  out  1  stage accepts the instruction this cycle.
- `flush`  in  1  squash (branch taken / trap).
- `ex_ready`  in  1  execute accepts `ex_*` this cycle.
- `rf_rs1_addr`, `rf_rs2_addr`  out  `RAW`  register-file read addresses (combinational).
- `ex_valid`  out  1  `ex_*` hold a valid instruction.
- `ex_pc`  out  `XLEN`  PC.
- `ex_imm`  out  `XLEN`  sign-extended immediate.
- `ex_rs1`, `ex_rs2`, `ex_rd`  out  `RAW`  register indices.
- `ex_alu_op`  out  4  ALU operation code.
- `ex_src1_pc`  out  1  ALU operand A is PC.
- `ex_src2_imm`  out  1  ALU operand B is immediate.
- `ex_funct3`  out  3  raw funct3 (branch condition / memory size).
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_is_branch`, `ex_is_jump`, `ex_illegal`  out  1 each  control flags.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous, active-low on `rst_n`.
- Reset values: all `ex_*` registers 0 (`ex_valid`=0, `ex_alu_op`=ADD encoding 0).
- Reset priority: reset > flush > stall > accept.
- Hold condition: `hold` = `ex_valid` & !`ex_ready`.
- Load-use condition: `load_use` = `ex_valid` & `ex_mem_read` & (`ex_rd`!=0) & `if_valid` & ((uses_rs1 & rs1==`ex_rd`) | (uses_rs2 & rs2==`ex_rd`)).
  - uses_rs1: all opcodes except LUI, AUIPC, JAL.
  - uses_rs2: BRANCH, STORE, OP.
- `if_ready` = !`hold` & !`load_use` & !`flush`. Combinational; reset state gives `if_ready`=1.
- Read-address mux:
  - `rf_rs1_addr`/`rf_rs2_addr` = `hold` ? `ex_rs1`/`ex_rs2` : `if_instr[19:15]`/`if_instr[24:20]`.
  - While held, the register file re-reads the held sources, so same-cycle writebacks are picked up.
- Edge update, in priority order:
  - `flush`: `ex_valid`<=0. The input is not accepted, even if `hold`.
  - `hold`: all `ex_*` unchanged.
  - `load_use`: `ex_valid`<=0 (one bubble). The input stays pending.
  - Accept (`if_valid`): `ex_*` <= decoded fields, `ex_valid`<=1.
  - Otherwise: `ex_valid`<=0.
- Latency: 1 cycle from accept to `ex_valid`. Full throughput when `ex_ready`=1 and there is no hazard.
- Decode rules:
  - `ex_rd` is forced to 0 when `ex_reg_write`=0.
  - rd=x0 keeps `reg_write`=1, so execute ignores it.
- Immediates:
  - I, S, B, U, J formats per RV32I.
  - B and J immediates have bit 0 = 0.
  - All immediates sign-extended from the instruction MSB; U-type is `instr[31:12]`<<12.
- ALU op and operand selection:
  - LOAD, STORE, JAL, JALR, AUIPC: ADD.
  - AUIPC and JAL: `src1_pc`=1.
  - BRANCH: SUB with `src2_imm`=0; execute compares using `funct3`.
  - LUI: PASS_B.
  - OP / OP-IMM: from funct3, with funct7[5] selecting SUB (OP only) and SRA (both).
- Illegal instructions:
  - Any unknown opcode, or `instr[1:0]`!=2'b11, sets `ex_illegal`=1.
  - All write, memory, branch and jump flags are 0 for an illegal instruction.
  - The instruction still flows through (`ex_valid`=1).
- `flush` during `load_use` or `hold`: the flush wins, and the held instruction is discarded.

Decomposition:
- Shared define header: opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP) and the 4-bit ALU op encodings.
  - ADD=0, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B.
- Sub-module `instr_decoder`: purely combinational; instruction -> control bundle + immediate + uses_rs1/uses_rs2.
- `decode_stage` keeps the handshake, hazard logic, address mux and registers.

Test Plan:
1. `rst_n`=0 for 2 cycles with `if_valid`=1 -> `ex_valid`=0 and all `ex_*`=0 throughout. After release with `ex_ready`=1, `if_ready`=1.
2. ADDI x1,x0,5 (0x00500093), pc=0x100 -> in the accept cycle `rf_rs1_addr`=0. Next cycle: `ex_valid`=1, `ex_pc`=0x100, `ex_rd`=1, `ex_imm`=5, `ex_alu_op`=ADD, `ex_src2_imm`=1, `ex_reg_write`=1.
3. LW x2,0(x1) (0x0000A103) followed by ADD x3,x2,x2 (0x002101B3), `ex_ready`=1 ->
   - After LW is accepted: `if_ready`=0 for one cycle, then `ex_valid`=0 (bubble).
   - ADD is then accepted: `ex_rs1`=`ex_rs2`=2, `ex_rd`=3.
4. ADD held with `ex_ready`=0 for 3 cycles -> `ex_*` stable, `rf_rs1_addr`=`rf_rs2_addr`=2, `if_ready`=0. The instruction is released on the first `ex_ready`=1.
5. `flush`=1 with `if_valid`=1 while holding -> `if_ready`=0. Next cycle `ex_valid`=0, and the fetch instruction is still pending.
6. BEQ x0,x0,-4 (0xFE000EE3) -> `ex_imm`=0xFFFFFFFC, `ex_is_branch`=1, `ex_alu_op`=SUB, `ex_rd`=0. Then 0xFFFFFFFF -> `ex_illegal`=1, `reg_write`/`mem_read`/`mem_write`=0.
